// File: rtl/mau_cluster_scheduler.sv
// ---------------------------------------------------------------------------
// mau_cluster_scheduler
//
// Job scheduler for a cluster of NUM_LANES matrix acceleration units (MAUs).
// Host jobs are buffered in a small FIFO and dispatched either in gang mode
// (one job fans out across every lane, each lane offset by LANE_STRIDE) or in
// independent mode (one job per lane, round-robin). Per-lane claim/busy
// tracking decides when results are ready, and host reads are steered to the
// lanes strictly in dispatch order. A requested mode change first drains the
// cluster and is committed only once everything has been read back.
//
// Ports
//   clk, reset       clock and synchronous active-high reset
//   mode             requested mode: 0 = gang, 1 = independent
//   job_valid/ready  job handshake; job_addr is the job block index
//   lane_busy        per-lane MAU busy flags
//   lane_start       per-lane one-cycle start pulse
//   lane_addr        per-lane matRAM base address, lane i at [i*ADDR_W +: ADDR_W]
//   read_output      host request for the next result word
//   lane_read        one-hot read strobe (combinational with read_output)
//   read_err         one-cycle pulse when the next lane had no result
//   all_busy/any_busy  AND / OR of lane_busy
//   queue_count      FIFO occupancy
//   mode_q           committed operating mode
// ---------------------------------------------------------------------------
module mau_cluster_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int ADDR_W      = 10,
  parameter int LANE_STRIDE = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [8:0]                       job_addr,
  input  logic [NUM_LANES-1:0]             lane_busy,
  output logic [NUM_LANES-1:0]             lane_start,
  output logic [NUM_LANES*ADDR_W-1:0]      lane_addr,
  input  logic                             read_output,
  output logic [NUM_LANES-1:0]             lane_read,
  output logic                             read_err,
  output logic                             all_busy,
  output logic                             any_busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             mode_q
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 mode_d;
  logic [8:0]           fifo_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     hd_ptr_q, hd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_LANES-1:0] claimed_q, claimed_d;
  logic [NUM_LANES-1:0] seen_busy_q, seen_busy_d;
  logic [NUM_LANES-1:0] lane_start_q, lane_start_d;
  logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]    lane_addr_q [NUM_LANES];
  logic [ADDR_W-1:0]    lane_addr_d [NUM_LANES];
  logic                 read_err_q, read_err_d;

  logic                 full, empty, push, pop;
  logic                 dispatch_en, gang_go, indep_go, rd_hit, any_claimed;
  logic [NUM_LANES-1:0] result_ready;
  logic [8:0]           head_job;
  logic [9:0]           head_raw;
  logic [ADDR_W-1:0]    head_base;

  // FIFO status, handshake and the dispatch/read decisions for this cycle.
  // A lane is claimed from the very edge that raises its start pulse, so a
  // just-started lane is never mistaken for a free one.
  always_comb begin
    full        = (count_q == CNT_W'(QUEUE_DEPTH));
    empty       = (count_q == '0);
    job_ready   = !full && (state_q != DRAIN);
    push        = job_valid && job_ready;
    head_job    = fifo_mem_q[hd_ptr_q];
    head_raw    = {head_job, 1'b0};
    head_base   = ADDR_W'(head_raw);
    any_claimed = |claimed_q;
    dispatch_en = !empty && (state_q != IDLE);
    gang_go     = dispatch_en && !mode_q && (claimed_q == '0);
    indep_go    = dispatch_en && mode_q && !claimed_q[rr_ptr_q];
    pop         = gang_go || indep_go;
    // A lane only counts as done after it has been seen busy at least once.
    result_ready = claimed_q & seen_busy_q & ~lane_busy;
    rd_hit       = read_output && result_ready[rd_ptr_q];
    lane_read    = '0;
    if (rd_hit) begin
      lane_read[rd_ptr_q] = 1'b1;
    end
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    hd_ptr_d = hd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      hd_ptr_d = hd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Per-lane flags, start pulses, base addresses and read sequencing.
  // Lanes that are not started this cycle keep their previous address.
  always_comb begin
    lane_start_d = '0;
    lane_addr_d  = lane_addr_q;
    claimed_d    = claimed_q;
    seen_busy_d  = seen_busy_q | (claimed_q & lane_busy);
    rr_ptr_d     = rr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    read_err_d   = read_output && !result_ready[rd_ptr_q];
    if (gang_go) begin
      lane_start_d = '1;
      claimed_d    = '1;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_addr_d[i] = head_base + ADDR_W'(i * LANE_STRIDE);
      end
    end
    if (indep_go) begin
      lane_start_d[rr_ptr_q] = 1'b1;
      claimed_d[rr_ptr_q]    = 1'b1;
      lane_addr_d[rr_ptr_q]  = head_base;
      rr_ptr_d               = rr_ptr_q + LANE_W'(1);
    end
    if (rd_hit) begin
      claimed_d[rd_ptr_q]   = 1'b0;
      seen_busy_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = rd_ptr_q + LANE_W'(1);
    end
  end

  // Mode FSM: a new mode is committed only from IDLE, i.e. with the FIFO empty
  // and every lane read back. RUN stays put when a job arrives this cycle so
  // the job is dispatched without a detour through IDLE.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (mode != mode_q) begin
          mode_d = mode;
        end else if (push || !empty) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (mode != mode_q) begin
          state_d = DRAIN;
        end else if (empty && !push && !any_claimed) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (empty && !any_claimed) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job storage; stale entries are harmless because the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= job_addr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      wr_ptr_q     <= '0;
      hd_ptr_q     <= '0;
      count_q      <= '0;
      claimed_q    <= '0;
      seen_busy_q  <= '0;
      lane_start_q <= '0;
      rr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      read_err_q   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_addr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      hd_ptr_q     <= hd_ptr_d;
      count_q      <= count_d;
      claimed_q    <= claimed_d;
      seen_busy_q  <= seen_busy_d;
      lane_start_q <= lane_start_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      read_err_q   <= read_err_d;
      lane_addr_q  <= lane_addr_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_addr
    assign lane_addr[g*ADDR_W +: ADDR_W] = lane_addr_q[g];
  end

  assign lane_start  = lane_start_q;
  assign read_err    = read_err_q;
  assign queue_count = count_q;
  assign all_busy    = &lane_busy;
  assign any_busy    = |lane_busy;

endmodule

// File: tb/tb_mau_cluster_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mau_cluster_scheduler
//
// Directed bench for mau_cluster_scheduler (4 lanes, 10-bit addresses,
// stride 4, queue depth 4). Each pushed job records the start it should
// produce in a scoreboard queue; a negedge monitor pops and compares every
// start pulse. A tiny MAU model raises busy one cycle after start for three
// cycles, and holdBusy can pin lanes busy.
// ---------------------------------------------------------------------------
module tb_mau_cluster_scheduler;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][9:0] addr;
  } startExp_t;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        jobValid;
  logic        jobReady;
  logic [8:0]  jobAddr;
  logic [3:0]  laneBusy;
  logic [3:0]  laneStart;
  logic [39:0] laneAddr;
  logic        readOutput;
  logic [3:0]  laneRead;
  logic        readErr;
  logic        allBusy;
  logic        anyBusy;
  logic [2:0]  queueCount;
  logic        modeQ;

  logic [3:0]  holdBusy;
  int          busyCnt [4];
  startExp_t   expStartQ [$];
  int          expMode;
  int          expRr;
  int          checkCount;
  int          passCount;
  int          failCount;

  mau_cluster_scheduler #(
    .NUM_LANES  (4),
    .ADDR_W     (10),
    .LANE_STRIDE(4),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .job_valid  (jobValid),
    .job_ready  (jobReady),
    .job_addr   (jobAddr),
    .lane_busy  (laneBusy),
    .lane_start (laneStart),
    .lane_addr  (laneAddr),
    .read_output(readOutput),
    .lane_read  (laneRead),
    .read_err   (readErr),
    .all_busy   (allBusy),
    .any_busy   (anyBusy),
    .queue_count(queueCount),
    .mode_q     (modeQ)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MAU model: busy rises the cycle after a start pulse and lasts 3 cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        busyCnt[i] <= 0;
      end else if (laneStart[i]) begin
        busyCnt[i] <= 3;
      end else if (busyCnt[i] > 0) begin
        busyCnt[i] <= busyCnt[i] - 1;
      end
    end
  end

  // Busy seen by the scheduler combines the model with the forced hold.
  always_comb begin
    laneBusy = holdBusy;
    for (int i = 0; i < 4; i++) begin
      if (busyCnt[i] != 0) begin
        laneBusy[i] = 1'b1;
      end
    end
  end

  // One comparison: counted, asserted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every start pulse must match the oldest expected start in the scoreboard.
  always @(negedge clk) begin
    if (laneStart !== 4'b0000) begin
      if (expStartQ.size() == 0) begin
        checkOutput("unexpected_start", 64'(laneStart), 64'(0));
      end else begin
        startExp_t e;
        e = expStartQ.pop_front();
        checkOutput("start_mask", 64'(laneStart), 64'(e.mask));
        for (int i = 0; i < 4; i++) begin
          if (e.mask[i]) begin
            checkOutput("start_addr", 64'(laneAddr[i*10 +: 10]), 64'(e.addr[i]));
          end
        end
      end
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one job, recording the start it should cause; optionally checks the
  // queue occupancy seen just before the handshake.
  task automatic applyStimulus(input logic [8:0] a, input int expCnt);
    startExp_t  e;
    logic [9:0] base;
    int         waited;
    base   = {a, 1'b0};
    e.mask = 4'b0000;
    e.addr = '0;
    if (expMode == 0) begin
      e.mask = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        e.addr[i] = base + 10'(i * 4);
      end
    end else begin
      e.mask[expRr] = 1'b1;
      e.addr[expRr] = base;
      expRr = (expRr + 1) % 4;
    end
    expStartQ.push_back(e);
    jobValid = 1'b1;
    jobAddr  = a;
    @(negedge clk);
    if (expCnt >= 0) begin
      checkOutput("count_before_push", 64'(queueCount), 64'(expCnt));
    end
    waited = 0;
    while (!jobReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("push_accept", 64'(jobReady), 64'(1));
    @(posedge clk);
    #1;
    jobValid = 1'b0;
  endtask

  // Wait until at most n expected starts remain outstanding.
  task automatic waitQueue(input int n);
    int waited;
    waited = 0;
    while (expStartQ.size() > n && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("start_wait", 64'(expStartQ.size() <= n), 64'(1));
    tick();
  endtask

  // One host read: lane_read checked in the request cycle, read_err after.
  task automatic doRead(input logic [3:0] expRead);
    readOutput = 1'b1;
    @(negedge clk);
    checkOutput("lane_read", 64'(laneRead), 64'(expRead));
    @(posedge clk);
    #1;
    readOutput = 1'b0;
    @(negedge clk);
    checkOutput("read_err", 64'(readErr), 64'(expRead == 4'b0000));
    tick();
  endtask

  // n reads walking lanes upward from firstLane, each after a settle gap.
  task automatic readSeq(input int firstLane, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (5) tick();
      doRead(4'(1 << ((firstLane + k) % 4)));
    end
  endtask

  // Directed sequence: reset, gang, independent, backpressure, drain, reset.
  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    expMode    = 0;
    expRr      = 0;
    reset      = 1'b1;
    mode       = 1'b0;
    jobValid   = 1'b0;
    jobAddr    = '0;
    readOutput = 1'b0;
    holdBusy   = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_start", 64'(laneStart), 64'(0));
    checkOutput("reset_addr", 64'(laneAddr), 64'(0));
    checkOutput("reset_count", 64'(queueCount), 64'(0));
    checkOutput("reset_mode", 64'(modeQ), 64'(0));
    checkOutput("reset_ready", 64'(jobReady), 64'(1));
    tick();

    $display("[TB] gang dispatch");
    applyStimulus(9'd5, 0);
    waitQueue(0);
    checkOutput("gang_addr", 64'(laneAddr), 64'({10'd22, 10'd18, 10'd14, 10'd10}));
    checkOutput("gang_count", 64'(queueCount), 64'(0));
    readSeq(0, 4);

    $display("[TB] independent round-robin");
    mode    = 1'b1;
    expMode = 1;
    repeat (3) tick();
    checkOutput("mode_indep", 64'(modeQ), 64'(1));
    applyStimulus(9'd1, 0);
    applyStimulus(9'd2, 1);
    applyStimulus(9'd3, 1);
    applyStimulus(9'd4, 1);
    applyStimulus(9'd5, 1);
    waitQueue(1);
    repeat (6) tick();
    checkOutput("fifth_waits_count", 64'(queueCount), 64'(1));
    checkOutput("fifth_not_started", 64'(expStartQ.size()), 64'(1));
    doRead(4'b0001);
    waitQueue(0);
    readSeq(1, 4);
    doRead(4'b0000);

    $display("[TB] backpressure");
    holdBusy = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(9'(20 + j), -1);
    end
    repeat (2) tick();
    checkOutput("full_count", 64'(queueCount), 64'(4));
    checkOutput("full_ready", 64'(jobReady), 64'(0));
    checkOutput("all_busy", 64'(allBusy), 64'(1));
    holdBusy = 4'b0000;
    tick();
    doRead(4'b0010);
    applyStimulus(9'd28, 3);
    tick();
    checkOutput("refill_count", 64'(queueCount), 64'(4));
    checkOutput("refill_ready", 64'(jobReady), 64'(0));
    readSeq(2, 8);
    waitQueue(0);
    checkOutput("drained_count", 64'(queueCount), 64'(0));

    $display("[TB] mode change drain");
    mode    = 1'b0;
    expMode = 0;
    repeat (3) tick();
    checkOutput("mode_gang", 64'(modeQ), 64'(0));
    applyStimulus(9'd40, 0);
    applyStimulus(9'd41, -1);
    applyStimulus(9'd42, -1);
    checkOutput("drain_queued", 64'(queueCount), 64'(2));
    mode = 1'b1;
    tick();
    checkOutput("drain_ready0", 64'(jobReady), 64'(0));
    checkOutput("drain_mode_hold", 64'(modeQ), 64'(0));
    readSeq(2, 4);
    checkOutput("drain_ready1", 64'(jobReady), 64'(0));
    readSeq(2, 4);
    checkOutput("drain_ready2", 64'(jobReady), 64'(0));
    readSeq(2, 4);
    checkOutput("idle_mode_old", 64'(modeQ), 64'(0));
    checkOutput("idle_ready", 64'(jobReady), 64'(1));
    tick();
    checkOutput("mode_committed", 64'(modeQ), 64'(1));

    $display("[TB] reset mid-operation and address wrap");
    expMode = 1;
    applyStimulus(9'd60, -1);
    applyStimulus(9'd61, -1);
    waitQueue(0);
    reset = 1'b1;
    mode  = 1'b0;
    tick();
    checkOutput("mid_reset_start", 64'(laneStart), 64'(0));
    checkOutput("mid_reset_addr", 64'(laneAddr), 64'(0));
    checkOutput("mid_reset_count", 64'(queueCount), 64'(0));
    checkOutput("mid_reset_err", 64'(readErr), 64'(0));
    checkOutput("mid_reset_read", 64'(laneRead), 64'(0));
    checkOutput("mid_reset_mode", 64'(modeQ), 64'(0));
    checkOutput("mid_reset_busy", 64'(anyBusy), 64'(0));
    reset   = 1'b0;
    expMode = 0;
    expRr   = 0;
    tick();
    applyStimulus(9'd511, 0);
    waitQueue(0);
    checkOutput("wrap_lane3", 64'(laneAddr[39:30]), 64'(10));
    checkOutput("scoreboard_drained", 64'(expStartQ.size()), 64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
